// File: rtl/key_pkg.sv
// key_pkg: shared selection width, reset codes and wrap-around increment helper
package key_pkg;
   localparam int SEL_W = 4;
   typedef logic [SEL_W-1:0] sel_t;
   localparam sel_t MODE_RESET = '0;
   localparam sel_t LED_RESET  = '0;
   function automatic sel_t wrap_inc(input sel_t v, input sel_t last);
      return (v == last) ? '0 : v + sel_t'(1);
   endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus counter debounce with registered press pulse
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic level,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          settle;
   assign settle = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   // bring the raw key into the clock domain; released level on reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= 2'b11;
      else sync <= {sync[0], key_n};
   // count while the synchronized level disagrees, accept it after the full window
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b1;
         press <= 1'b0;
      end else begin
         cnt   <= (sync[1] == level || settle) ? '0 : cnt + CW'(1);
         level <= settle ? sync[1] : level;
         press <= settle && !sync[1];
      end
endmodule

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: debounced mode/LED push-buttons stepping the selector codes; KEY_LONG_PRESS_EN adds long-press reset
module key_mode_ctrl import key_pkg::*; #(
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int MODE_NUM          = 4,
   parameter int LED_NUM           = 8,
   parameter int LONG_PRESS_CYCLES = 100000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_mode_n,
   input  logic             key_led_n,
   output logic [SEL_W-1:0] mode_select,
   output logic [SEL_W-1:0] led_select,
   output logic             sel_changed
);
   localparam sel_t MODE_LAST = sel_t'(MODE_NUM - 1);
   localparam sel_t LED_LAST  = sel_t'(LED_NUM - 1);
   logic mode_level, mode_press, led_level_unused, led_press, hold_fire;
   sel_t mode_nx, led_nx;
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
      .clk(clk), .rst_n(rst_n), .key_n(key_mode_n), .level(mode_level), .press(mode_press)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_led (
      .clk(clk), .rst_n(rst_n), .key_n(key_led_n), .level(led_level_unused), .press(led_press)
   );
`ifdef KEY_LONG_PRESS_EN
   localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
   logic [HW-1:0] hold_cnt;
   // count debounced-low cycles of the mode key, parking one past the trigger value
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hold_cnt <= '0;
      else hold_cnt <= mode_level ? '0 :
                       (hold_cnt == HW'(LONG_PRESS_CYCLES)) ? hold_cnt : hold_cnt + HW'(1);
   assign hold_fire = !mode_level && (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));
`else
   logic mode_level_unused;
   assign mode_level_unused = mode_level;
   assign hold_fire = 1'b0;
`endif
   // long-press reset beats a mode press, which beats an LED press
   always_comb begin
      mode_nx = hold_fire ? MODE_RESET :
                mode_press ? wrap_inc(mode_select, MODE_LAST) : mode_select;
      led_nx  = (hold_fire || mode_press) ? LED_RESET :
                led_press ? wrap_inc(led_select, LED_LAST) : led_select;
   end
   // selection registers and change pulse
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mode_select <= MODE_RESET;
         led_select  <= LED_RESET;
         sel_changed <= 1'b0;
      end else begin
         mode_select <= mode_nx;
         led_select  <= led_nx;
         sel_changed <= (mode_nx != mode_select) || (led_nx != led_select);
      end
endmodule

// File: doc/key_mode_ctrl.md
# key_mode_ctrl

Front-panel input controller that produces the `mode_select` and `led_select` codes consumed by the LED flash-mode selector. It synchronizes and debounces two raw active-low push-buttons and turns each debounced press into a single increment of the corresponding code. It sits between the board key pins and the selector, which is the consumer of its outputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a key level (20 ms at 50 MHz); minimum 2.
- `MODE_NUM`, default 4: number of valid modes; `mode_select` wraps within 0..MODE_NUM-1; range 1..16.
- `LED_NUM`, default 8: number of selectable LEDs; `led_select` wraps within 0..LED_NUM-1; range 1..16.
- `LONG_PRESS_CYCLES`, default 100000000: hold time for long-press reset; used only with `KEY_LONG_PRESS_EN`.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous reset, active-low.
- `key_mode_n` input 1: raw mode button, asynchronous, low = pressed.
- `key_led_n` input 1: raw LED button, asynchronous, low = pressed.
- `mode_select` output 4: current mode code to the selector.
- `led_select` output 4: current LED index to the selector.
- `sel_changed` output 1: one-cycle pulse in the cycle after either output changes.

## Operation
- Per key: 2-flop synchronizer, then debounce. The synchronizer and stable-level registers reset to 1 (released).
- Debounce: a counter runs while the synchronized level differs from the stable level and clears when they match. When the count reaches DEBOUNCE_CYCLES-1 with the level still differing, the stable level takes the new value and the counter clears.
- Press: a one-cycle pulse, registered together with a stable 1->0 transition. Releases produce no pulse.
- Mode press: `mode_select` <= (mode_select == MODE_NUM-1) ? 0 : mode_select+1; `led_select` <= 0.
- LED press: `led_select` <= (led_select == LED_NUM-1) ? 0 : led_select+1; `mode_select` is unchanged.
- Simultaneous press pulses: the mode press wins. `mode_select` increments and `led_select` goes to 0; the LED press is discarded.
- `sel_changed` pulses whenever an output register was written with a different value.
- A bounce shorter than DEBOUNCE_CYCLES is fully rejected and produces no pulse.
- A held key produces no auto-repeat.

## Timing
- Reset values: `mode_select`=0, `led_select`=0, `sel_changed`=0, all counters 0.
- Raw key held low from before edge 0:
  - synchronized low after edge 2;
  - stable low and press pulse at edge 2+DEBOUNCE_CYCLES;
  - output update at edge 3+DEBOUNCE_CYCLES;
  - `sel_changed` high for the cycle after edge 3+DEBOUNCE_CYCLES.
- Reset asserted mid-debounce or mid-press: all state clears immediately. A key still held at reset release is seen as a new press after the full debounce.
- Back-to-back presses need a release and a re-press, each debounced, so they are at least 2*DEBOUNCE_CYCLES apart.

## Configuration
- `KEY_LONG_PRESS_EN` defined:
  - a hold counter runs while the debounced mode key is low;
  - when it reaches LONG_PRESS_CYCLES-1, `mode_select` and `led_select` go to 0 on the next edge and `sel_changed` pulses if either changed;
  - the counter then saturates, with no further action until release;
  - the short-press increment at press time still occurs.
- `KEY_LONG_PRESS_EN` undefined: no hold counter exists, and holding a key has no effect beyond the single press.

## Structure
- Package `key_pkg`: `SEL_W`=4 and the reset codes `MODE_RESET`=0 and `LED_RESET`=0.
- Sub-module `key_debounce`, instantiated twice. Parameter DEBOUNCE_CYCLES; ports `clk`, `rst_n`, `key_n`, `level` (stable level), `press` (pulse).
- The top contains the selection registers, the priority logic and the optional hold counter.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, MODE_NUM=4, LED_NUM=8, LONG_PRESS_CYCLES=20.
- Reset, then hold `key_mode_n` low for 10 cycles -> `mode_select` goes 0->1 at edge 7; `sel_changed` is high exactly one cycle; `led_select`=0.
- 3-cycle low glitch on `key_led_n` -> no press, `led_select` stays 0, `sel_changed` never asserts.
- 9 debounced LED presses -> `led_select` steps 1..7, wraps to 0, then 1.
- Set `led_select`=5, then press the mode key 4 times -> `mode_select` goes 1,2,3,0; `led_select` is 0 after the first press.
- Both keys pressed on the same cycle from mode=2, led=3 -> mode=3, led=0, and exactly one `sel_changed` pulse.
- With `KEY_LONG_PRESS_EN`, from mode=1 hold the mode key for 40 cycles -> mode=2 at edge 7, then mode=0 and led=0 after 20 more debounced-low cycles; no further change until release.
- Without the macro, the same stimulus -> mode stays 2.
- Assert `rst_n` low mid-debounce, release it with the key still held -> outputs are 0, and a press registers DEBOUNCE_CYCLES+3 edges after reset release.
